// File: rtl/alu_operand_sel_pipe_if.sv
// Operand-select pipe bus: accepts a select index plus the packed operand set
// and returns the registered selected operand with its index and error flag.
interface alu_operand_sel_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic                    w_InValid;
    logic                    w_InReady;
    logic [SEL_W-1:0]        w_Sel;
    logic [NUM_IN*WIDTH-1:0] w_In;
    logic [WIDTH-1:0]        w_Out;
    logic [SEL_W-1:0]        w_OutSel;
    logic                    w_SelErr;
    logic                    w_OutValid;
    logic                    w_OutReady;

    // Operand source / ALU side (drives the beat, consumes the result)
    modport master (
        output w_InValid, w_Sel, w_In, w_OutReady,
        input  w_InReady, w_Out, w_OutSel, w_SelErr, w_OutValid
    );

    // Selector pipe side
    modport slave (
        input  w_InValid, w_Sel, w_In, w_OutReady,
        output w_InReady, w_Out, w_OutSel, w_SelErr, w_OutValid
    );
endinterface

// File: rtl/alu_operand_sel_pipe.sv
// ALU operand selector: picks one of NUM_IN packed operands by index and
// registers it into a main stage backed by a one-entry skid register, so the
// control FSM can stall the ALU without losing a selected operand.
module alu_operand_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_operand_sel_pipe_if.slave bus
);
    localparam int              SLOTS     = 1 << SEL_W;
    localparam logic [SEL_W:0]  NUM_IN_W  = (SEL_W + 1)'(NUM_IN);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
        logic             valid;
    } entry_t;

    localparam entry_t EMPTY = '0;

    entry_t m_reg, m_next;
    entry_t s_reg, s_next;
    entry_t new_beat;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    // Every select code gets a slot; codes beyond NUM_IN read as zero so an
    // illegal select delivers a clean zero operand alongside the error flag.
    logic [WIDTH-1:0] operand [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_IN) begin : g_live
                assign operand[gi] = bus.w_In[gi*WIDTH +: WIDTH];
            end else begin : g_void
                assign operand[gi] = '0;
            end
        end
    endgenerate

    // Ready depends only on the skid register (and reset), never on w_OutReady.
    assign in_ready = !s_reg.valid && !reset;
    assign in_fire  = bus.w_InValid && in_ready;
    assign out_fire = m_reg.valid && bus.w_OutReady;

    // Build the beat that would be captured this cycle
    always_comb begin
        new_beat       = EMPTY;
        new_beat.data  = operand[bus.w_Sel];
        new_beat.sel   = bus.w_Sel;
        new_beat.err   = ({1'b0, bus.w_Sel} >= NUM_IN_W);
        new_beat.valid = 1'b1;
    end

    // Main/skid next-state: M refills from S first, S only absorbs a beat
    // that arrives while M is stalled.
    always_comb begin
        m_next = m_reg;
        s_next = s_reg;
        if (!m_reg.valid) begin
            if (in_fire) begin
                m_next = new_beat;
            end
        end else if (out_fire) begin
            if (s_reg.valid) begin
                m_next       = s_reg;
                s_next.valid = 1'b0;
            end else if (in_fire) begin
                m_next = new_beat;
            end else begin
                // Clear the whole entry so idle outputs read zero
                m_next = EMPTY;
            end
        end else if (in_fire) begin
            s_next = new_beat;
        end
    end

    // State registers; reset discards any held beat immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= EMPTY;
            s_reg <= EMPTY;
        end else begin
            m_reg <= m_next;
            s_reg <= s_next;
        end
    end

    assign bus.w_InReady  = in_ready;
    assign bus.w_Out      = m_reg.data;
    assign bus.w_OutSel   = m_reg.sel;
    assign bus.w_SelErr   = m_reg.err;
    assign bus.w_OutValid = m_reg.valid;

endmodule

// File: doc/alu_operand_sel_pipe.md
Name: alu_operand_sel_pipe

Overview:
Parametrised successor to the datapath's 4:1 ALU-source selector. It picks one of NUM_IN packed WIDTH-bit operands by index and registers the result into an output stage with a valid/ready handshake and a one-entry skid buffer. This lets the multicycle control FSM stall the ALU without losing a selected operand. It sits between the operand sources (PC, A, sign-extend, MDR, …) and the ALU operand port.

Parameters:
WIDTH, 32, operand width in bits
NUM_IN, 4, number of selectable inputs (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
w_InValid  input  1  upstream presents a select plus operand set this cycle
w_InReady  output  1  block can accept; transfer when w_InValid && w_InReady
w_Sel  input  SEL_W  operand index; input i occupies w_In[i*WIDTH +: WIDTH]
w_In  input  NUM_IN*WIDTH  packed operand bus
w_Out  output  WIDTH  selected operand, registered
w_OutSel  output  SEL_W  index that produced w_Out, registered
w_SelErr  output  1  registered flag: this beat had w_Sel >= NUM_IN
w_OutValid  output  1  w_Out, w_OutSel and w_SelErr are valid
w_OutReady  input  1  downstream accepts; transfer when w_OutValid && w_OutReady

Behaviour:
- Selection is combinational on the accepted beat and is captured at the edge.
- If w_Sel < NUM_IN, the captured data is w_In[w_Sel*WIDTH +: WIDTH] and SelErr is 0.
- If w_Sel >= NUM_IN, the captured data is all zeros and SelErr is 1. The beat is still delivered, never dropped.
- Storage is a main register (M) plus a skid register (S), each holding {data, sel, err, valid}.
- Outputs are driven directly from M. w_OutValid = M.valid.
- w_InReady = !S.valid. It is registered-state derived, with no combinational path from w_OutReady.
- Per rising edge, with in_fire = w_InValid && w_InReady and out_fire = M.valid && w_OutReady:
  - M empty, in_fire: M <= new beat.
  - M full, out_fire, S empty, in_fire: M <= new beat.
  - M full, out_fire, S empty, no in_fire: M.valid <= 0.
  - M full, no out_fire, in_fire (S must be empty): S <= new beat.
  - M full, out_fire, S full: M <= S and S.valid <= 0. No input is accepted that cycle because InReady is 0.
  - M full, no out_fire, S full: hold all state.
- Latency is 1 cycle from input acceptance to w_OutValid when unstalled. Throughput is 1 beat per cycle under continuous w_OutReady.
- Ordering is strict FIFO. Beats are never duplicated or reordered.
- While w_OutValid=1 && !w_OutReady, w_Out, w_OutSel and w_SelErr stay stable.
- Reset is asynchronous and takes effect immediately, including mid-transfer:
  - M.valid=0, S.valid=0.
  - w_Out=0, w_OutSel=0, w_SelErr=0, w_OutValid=0.
  - w_InReady=1 while reset is deasserted and the block is empty; w_InReady=0 while reset is asserted.
- Any beat held in M or S when reset asserts is discarded.
- Data and sel fields of empty registers are don't-care internally, but the outputs must read 0 whenever M.valid=0 after reset. The M data register is cleared on drain.

Test Plan:
- Pass-through: WIDTH=32, NUM_IN=4, inputs {0x1000,0xAAAA0001,0xFFFFFFFC,0x12345678}, w_OutReady=1, Sel sequence 0,1,2,3 on consecutive cycles -> one cycle later Out = 0x1000, 0xAAAA0001, 0xFFFFFFFC, 0x12345678 with OutSel 0..3, SelErr=0, OutValid held high for 4 cycles.
- Stall/skid: hold w_OutReady=0 and send Sel=1 then Sel=3 -> after the second edge InReady=0 and Out stays 0xAAAA0001. Raise OutReady -> next edge Out=0x12345678 and InReady=1; the following edge OutValid=0.
- Out-of-range: NUM_IN=3, SEL_W=2, Sel=3 with valid -> Out=0x00000000, OutSel=3, SelErr=1, OutValid=1 after 1 cycle. The next beat with Sel=0 has SelErr=0.
- Back-to-back with random OutReady: 200 beats with random Sel and operands, 50% OutReady -> scoreboard matches in order, no loss or duplicates, outputs stable while stalled.
- Async reset mid-operation: fill M and S, assert reset between edges -> OutValid=0 and Out=0 immediately. After deassert InReady=1 and no stale beat appears.
- Width/count sweep: WIDTH=16, NUM_IN=8, SEL_W=3, Sel=7 selects w_In[127:112] -> Out equals that slice after 1 cycle.
